iob_uart_tx_arb: RTL and testbench

Round-robin, packet-locking arbiter that shares the transmit path of one `iob_uart` instance among `N_REQ` byte-stream requesters. It acts as an IOb native-interface master on the UART register file: polls TXREADY, then writes TXDATA, one byte at a time. Once granted, a requester keeps the transmitter until it sends a byte flagged last, so packets are never interleaved on `txd`. Sits between on-chip producers (debug console, boot loader, DMA) and the UART slave port.

---
 rtl/iob_uart_tx_arb_if.sv | 23 ++
 rtl/iob_uart_tx_arb.sv | 165 ++++++++++++++++
 tb/tb_iob_uart_tx_arb.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/iob_uart_tx_arb_if.sv
// IOb native-interface bundle between the UART TX arbiter (master) and the UART register file (slave).
interface iob_uart_tx_arb_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
) ();
  logic                  iob_valid;
  logic [ADDR_W-1:0]     iob_addr;
  logic [DATA_W-1:0]     iob_wdata;
  logic [DATA_W/8-1:0]   iob_wstrb;
  logic                  iob_ready;
  logic                  iob_rvalid;
  logic [DATA_W-1:0]     iob_rdata;

  modport master (
    output iob_valid, iob_addr, iob_wdata, iob_wstrb,
    input  iob_ready, iob_rvalid, iob_rdata
  );

  modport slave (
    input  iob_valid, iob_addr, iob_wdata, iob_wstrb,
    output iob_ready, iob_rvalid, iob_rdata
  );
endinterface

// File: rtl/iob_uart_tx_arb.sv
// Round-robin, packet-locking arbiter sharing one iob_uart transmitter; polls TXREADY then writes TXDATA per byte.
// Optional lock timeout when IOB_UART_TX_ARB_TIMEOUT_EN is defined.
module iob_uart_tx_arb #(
  parameter int                  N_REQ        = 4,
  parameter int                  ADDR_W       = 3,
  parameter int                  DATA_W       = 32,
  parameter int                  TXDATA_ADDR  = 0,
  parameter int                  TXREADY_ADDR = 1,
  parameter logic [DATA_W/8-1:0] TXDATA_WSTRB = 4'b0001,
  parameter int                  TIMEOUT_W    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [8*N_REQ-1:0]   req_data_i,
  input  logic [N_REQ-1:0]     req_last_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic [N_REQ-1:0]     grant_o,
  output logic                 busy_o,
  iob_uart_tx_arb_if.master    iob,
  output logic                 timeout_o
);

  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_W < 1) begin : g_bad_param
    $error("iob_uart_tx_arb: illegal parameter value");
  end

  typedef enum logic [2:0] {IDLE, CAPTURE, POLL_REQ, POLL_RSP, WRITE, WAIT_BYTE} state_t;

  state_t              state, state_nx;
  logic [IDX_W-1:0]    rr_ptr, owner, pick;
  logic [7:0]          byte_q, cap_byte;
  logic                last_q, cap_last;
  logic                timeout_hit;
  logic                valid_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [DATA_W/8-1:0] wstrb_d;
  logic                unused_rdata;

  assign unused_rdata = ^iob.iob_rdata[DATA_W-1:1];

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // Walk offsets from the far end so the smallest offset from rr_ptr wins.
  always_comb begin : arb
    logic [IDX_W-1:0] cand;
    pick = '0;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (req_valid_i[cand]) pick = cand;
    end
  end

  always_comb begin
    cap_byte = '0;
    cap_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner == IDX_W'(i)) begin
        cap_byte = req_data_i[8*i +: 8];
        cap_last = req_last_i[i];
      end
    end
  end

`ifdef IOB_UART_TX_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] to_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                to_cnt <= '0;
    else if (state != WAIT_BYTE) to_cnt <= '0;
    else                         to_cnt <= to_cnt + 1'b1;
  end

  // A byte arriving on the same cycle as expiry still wins.
  assign timeout_hit = (state == WAIT_BYTE) && !req_valid_i[owner] && (&to_cnt);
`else
  assign timeout_hit = 1'b0;
`endif

  // State register and datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      grant_o       <= '0;
      byte_q        <= '0;
      last_q        <= 1'b0;
      timeout_o     <= 1'b0;
      iob.iob_valid <= 1'b0;
      iob.iob_addr  <= '0;
      iob.iob_wdata <= '0;
      iob.iob_wstrb <= '0;
    end else begin
      state         <= state_nx;
      timeout_o     <= timeout_hit;
      iob.iob_valid <= valid_d;
      iob.iob_addr  <= addr_d;
      iob.iob_wdata <= wdata_d;
      iob.iob_wstrb <= wstrb_d;
      if (state == IDLE && |req_valid_i) begin
        owner   <= pick;
        grant_o <= N_REQ'(1) << pick;
      end
      if (state == CAPTURE) begin
        byte_q <= cap_byte;
        last_q <= cap_last;
      end
      if ((state == WRITE && iob.iob_ready && last_q) || timeout_hit) begin
        grant_o <= '0;
        rr_ptr  <= next_idx(owner);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (|req_valid_i) state_nx = CAPTURE;
      CAPTURE:   state_nx = POLL_REQ;
      POLL_REQ:  if (iob.iob_ready) begin
                   if (iob.iob_rvalid) state_nx = iob.iob_rdata[0] ? WRITE : POLL_REQ;
                   else                state_nx = POLL_RSP;
                 end
      POLL_RSP:  if (iob.iob_rvalid) state_nx = iob.iob_rdata[0] ? WRITE : POLL_REQ;
      WRITE:     if (iob.iob_ready) state_nx = last_q ? IDLE : WAIT_BYTE;
      WAIT_BYTE: if (req_valid_i[owner]) state_nx = CAPTURE;
                 else if (timeout_hit)   state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Outputs: IOb request is computed from the next state so it is registered on entry.
  always_comb begin
    valid_d     = 1'b0;
    addr_d      = '0;
    wdata_d     = '0;
    wstrb_d     = '0;
    req_ready_o = (state == CAPTURE) ? grant_o : '0;
    busy_o      = (state != IDLE);
    case (state_nx)
      POLL_REQ: begin
        valid_d = 1'b1;
        addr_d  = ADDR_W'(TXREADY_ADDR);
      end
      WRITE: begin
        valid_d = 1'b1;
        addr_d  = ADDR_W'(TXDATA_ADDR);
        wstrb_d = TXDATA_WSTRB;
        for (int b = 0; b < DATA_W/8; b++) begin
          if (TXDATA_WSTRB[b]) wdata_d[8*b +: 8] = byte_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_iob_uart_tx_arb.sv
// Scoreboard bench for iob_uart_tx_arb: directed packets, IOb slave model, monitor pops expected TXDATA bytes.
module tb_iob_uart_tx_arb;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready, grant;
  logic           busy, timeout;

  always #5 clk = ~clk;

  iob_uart_tx_arb_if #(.ADDR_W(3), .DATA_W(32)) iob ();

  iob_uart_tx_arb #(
    .N_REQ(N), .ADDR_W(3), .DATA_W(32), .TXDATA_ADDR(0), .TXREADY_ADDR(1),
    .TXDATA_WSTRB(4'b0001), .TIMEOUT_W(4)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_last_i(req_last), .req_ready_o(req_ready), .grant_o(grant), .busy_o(busy),
    .iob(iob), .timeout_o(timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Requester stimulus storage
  logic [8:0] src_mem [N][16];
  int         src_cnt [N];
  int         src_idx [N];
  bit         rdy_seen[N];
  int         rdy_cnt [N];
  logic [7:0] exp_q[$];

  task automatic push_byte(input int r, input logic [7:0] d, input bit last, input bit expect_wr);
    src_mem[r][src_cnt[r]] = {last, d};
    src_cnt[r]++;
    if (expect_wr) exp_q.push_back(d);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      src_cnt[i] = 0; src_idx[i] = 0; rdy_seen[i] = 0; rdy_cnt[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rdy_seen[i]) begin src_idx[i]++; rdy_seen[i] = 0; end
      if (rst_n && req_ready[i]) begin rdy_seen[i] = 1; rdy_cnt[i]++; end
      if (src_idx[i] < src_cnt[i]) begin
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = src_mem[i][src_idx[i]][7:0];
        req_last[i]       = src_mem[i][src_idx[i]][8];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
  end

  // IOb slave model and write monitor
  int          rdy_dly = 0, poll_zeros = 0, wait_cnt = 0;
  int          n_reads = 0, n_writes = 0, hold_cyc = 0, to_cnt = 0;
  bit          holding = 0, stable_ok = 1;
  logic [2:0]  h_addr;
  logic [31:0] h_wdata;
  logic [3:0]  h_wstrb;
  logic [7:0]  exp_b;

  always @(negedge clk) begin
    if (timeout) to_cnt++;
    if (grant != '0) chk("grant_onehot", 64'($onehot(grant)), 64'd1);
    if (!rst_n) begin
      wait_cnt = 0; holding = 0;
      iob.iob_ready = 1'b0; iob.iob_rvalid = 1'b0; iob.iob_rdata = '0;
    end else if (iob.iob_valid) begin
      if (!holding) begin
        holding = 1; stable_ok = 1; hold_cyc = 0;
        h_addr = iob.iob_addr; h_wdata = iob.iob_wdata; h_wstrb = iob.iob_wstrb;
      end else if (h_addr !== iob.iob_addr || h_wdata !== iob.iob_wdata || h_wstrb !== iob.iob_wstrb) begin
        stable_ok = 0;
      end
      hold_cyc++;
      if (wait_cnt >= rdy_dly) begin
        iob.iob_ready = 1'b1; wait_cnt = 0; holding = 0;
        if (rdy_dly > 0) begin
          chk("req_stable", 64'(stable_ok), 64'd1);
          chk("hold_cycles", 64'(hold_cyc), 64'(rdy_dly + 1));
        end
        if (iob.iob_wstrb == 4'b0000) begin
          chk("rd_addr", 64'(iob.iob_addr), 64'd1);
          iob.iob_rvalid = 1'b1;
          iob.iob_rdata  = (poll_zeros > 0) ? 32'd0 : 32'd1;
          if (poll_zeros > 0) poll_zeros--;
          n_reads++;
        end else begin
          iob.iob_rvalid = 1'b0;
          n_writes++;
          chk("wr_addr_strb", {iob.iob_addr, iob.iob_wstrb}, {3'd0, 4'b0001});
          if (exp_q.size() == 0) begin
            chk("unexpected_wr", 64'(iob.iob_wdata), 64'hFFFF_FFFF_FFFF);
          end else begin
            exp_b = exp_q.pop_front();
            chk("wr_data", 64'(iob.iob_wdata), 64'(exp_b));
          end
        end
      end else begin
        iob.iob_ready = 1'b0; iob.iob_rvalid = 1'b0; wait_cnt++;
      end
    end else begin
      iob.iob_ready = 1'b0; iob.iob_rvalid = 1'b0;
    end
  end

  function automatic bit src_pending();
    for (int i = 0; i < N; i++) if (src_idx[i] < src_cnt[i]) return 1;
    return 0;
  endfunction

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy || src_pending()) && n < budget) begin
      @(negedge clk); n++;
    end
    chk(name, 64'(n >= budget), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  int r0, w0, c0, c2, n;

  initial begin
    repeat (3) @(negedge clk);
    #1 chk("reset_outputs", {req_ready, grant, busy, iob.iob_valid, iob.iob_addr, iob.iob_wstrb, iob.iob_wdata, timeout}, 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Simultaneous 3-byte packets from req0 and req2; req0 first, no interleave
    @(posedge clk); #1;
    push_byte(0, 8'hA0, 0, 1); push_byte(0, 8'hA1, 0, 1); push_byte(0, 8'hA2, 1, 1);
    push_byte(2, 8'hC0, 0, 1); push_byte(2, 8'hC1, 0, 1); push_byte(2, 8'hC2, 1, 1);
    wait_done("pkt_req0_req2_done", 300);

    // rr_ptr=3: req3 checked before req0
    r0 = n_reads; c0 = rdy_cnt[0];
    @(posedge clk); #1;
    push_byte(3, 8'h33, 1, 1); push_byte(0, 8'h41, 0, 1); push_byte(0, 8'h42, 1, 1);
    wait_done("wrap_done", 200);
    chk("grant_released", 64'(grant), 64'd0);
    chk("req0_ready_pulses", 64'(rdy_cnt[0] - c0), 64'd2);
    chk("wrap_reads", 64'(n_reads - r0), 64'd3);

    // rr_ptr=1 after req0 released: req1 beats req0
    @(posedge clk); #1;
    push_byte(1, 8'h11, 1, 1); push_byte(0, 8'h10, 1, 1);
    wait_done("rr_done", 200);

    // TXREADY low for 5 polls
    r0 = n_reads; w0 = n_writes; c2 = rdy_cnt[2];
    @(posedge clk); #1;
    poll_zeros = 5;
    push_byte(2, 8'h5A, 1, 1);
    wait_done("poll_done", 200);
    chk("poll_reads", 64'(n_reads - r0), 64'd6);
    chk("poll_writes", 64'(n_writes - w0), 64'd1);
    chk("poll_ready_pulses", 64'(rdy_cnt[2] - c2), 64'd1);

    // Slave ready delayed 3 cycles per transaction
    w0 = n_writes;
    @(posedge clk); #1;
    rdy_dly = 3;
    push_byte(1, 8'h77, 1, 1);
    wait_done("slow_done", 200);
    chk("slow_writes", 64'(n_writes - w0), 64'd1);
    rdy_dly = 0;

`ifdef IOB_UART_TX_ARB_TIMEOUT_EN
    // req1 stalls mid-packet while req3 waits
    @(posedge clk); #1;
    push_byte(1, 8'h61, 0, 1);
    n = 0;
    while (grant != 4'b0010 && n < 50) begin @(negedge clk); n++; end
    chk("req1_granted", 64'(grant), 64'h2);
    push_byte(3, 8'h62, 1, 1);
    wait_done("timeout_done", 300);
    chk("timeout_pulses", 64'(to_cnt), 64'd1);
`else
    chk("no_timeout_pulse", 64'(to_cnt), 64'd0);
`endif

    // Reset during WRITE of a mid-packet byte
    @(posedge clk); #1;
    rdy_dly = 20;
    push_byte(0, 8'h81, 0, 0); push_byte(0, 8'h82, 1, 0);
    n = 0;
    while (!(iob.iob_valid && iob.iob_wstrb != 4'b0000) && n < 100) begin @(negedge clk); n++; end
    chk("reached_write", 64'(n >= 100), 64'd0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {req_ready, grant, busy, iob.iob_valid, iob.iob_addr, iob.iob_wstrb, iob.iob_wdata, timeout}, 64'd0);
    src_idx[0] = src_cnt[0];
    rdy_dly = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    w0 = n_writes; c2 = rdy_cnt[2];
    @(posedge clk); #1;
    push_byte(2, 8'h9C, 1, 1);
    wait_done("post_reset_done", 200);
    chk("post_reset_ready", 64'(rdy_cnt[2] - c2), 64'd1);
    chk("post_reset_writes", 64'(n_writes - w0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
